// File: rtl/dispatch_request_router_if.sv
// Bundle of the handshake and status signals around dispatch_request_router.
//   master : environment side (warp scheduler plus the three execution units)
//   slave  : the router itself
// Signals:
//   s_tvalid_req / s_tready_req / dispatch_request : scheduler request channel
//   flush                                          : synchronous clear of all queues
//   sched_ready_{alu,lsu,sp}                       : per-class readiness to the scheduler
//   m_tvalid_x / m_tready_x / m_tdata_x            : per-class drain channels (x = alu, lsu, sp)
//   occ_{alu,lsu,sp}                               : queue occupancy
//   err                                            : one-cycle error flags
interface dispatch_request_router_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned OccW = $clog2(DEPTH) + 1;

  logic             s_tvalid_req;
  logic             s_tready_req;
  logic [102:0]     dispatch_request;
  logic             flush;
  logic             sched_ready_alu;
  logic             sched_ready_lsu;
  logic             sched_ready_sp;
  logic             m_tvalid_alu;
  logic             m_tready_alu;
  logic [99:0]      m_tdata_alu;
  logic             m_tvalid_lsu;
  logic             m_tready_lsu;
  logic [99:0]      m_tdata_lsu;
  logic             m_tvalid_sp;
  logic             m_tready_sp;
  logic [99:0]      m_tdata_sp;
  logic [OccW-1:0]  occ_alu;
  logic [OccW-1:0]  occ_lsu;
  logic [OccW-1:0]  occ_sp;
  logic [31:0]      err;

  modport master (
    output s_tvalid_req, dispatch_request, flush,
    output m_tready_alu, m_tready_lsu, m_tready_sp,
    input  s_tready_req, sched_ready_alu, sched_ready_lsu, sched_ready_sp,
    input  m_tvalid_alu, m_tdata_alu, m_tvalid_lsu, m_tdata_lsu, m_tvalid_sp, m_tdata_sp,
    input  occ_alu, occ_lsu, occ_sp, err
  );

  modport slave (
    input  s_tvalid_req, dispatch_request, flush,
    input  m_tready_alu, m_tready_lsu, m_tready_sp,
    output s_tready_req, sched_ready_alu, sched_ready_lsu, sched_ready_sp,
    output m_tvalid_alu, m_tdata_alu, m_tvalid_lsu, m_tdata_lsu, m_tvalid_sp, m_tdata_sp,
    output occ_alu, occ_lsu, occ_sp, err
  );
endinterface

// File: rtl/dispatch_request_router.sv
// Routes 103-bit warp dispatch requests into three independent first-word-fall-through
// queues (ALU, LSU, SPECIAL) selected by the one-hot class in request bits [2:0].
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset; discards all queued entries
//   bus   : dispatch_request_router_if.slave (request channel, flush, per-class drain
//           channels, per-class scheduler readiness, occupancies, error flags)
// err bits: [0] illegal class, [1] ALU overflow, [2] LSU overflow, [3] SPECIAL overflow.
module dispatch_request_router #(
  parameter int unsigned DEPTH = 4
) (
  input logic                        clk,
  input logic                        rst_n,
  dispatch_request_router_if.slave   bus
);

  localparam int unsigned NumCls = 3;
  localparam int unsigned DataW  = 100;
  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned OccW   = $clog2(DEPTH) + 1;

  // Queue storage and state, indexed 0 = ALU, 1 = LSU, 2 = SPECIAL.
  logic [DataW-1:0] r_mem [NumCls][DEPTH];
  logic [PtrW-1:0]  r_wptr [NumCls];
  logic [PtrW-1:0]  r_rptr [NumCls];
  logic [OccW-1:0]  r_occ  [NumCls];
  logic [NumCls-1:0] r_sched_ready;
  logic              r_s_tready;
  logic [3:0]        r_err;

  logic [NumCls-1:0] w_tready;
  logic [NumCls-1:0] w_push;
  logic [NumCls-1:0] w_pop;
  logic [NumCls-1:0] w_full;
  logic [NumCls-1:0] w_accept;
  logic [NumCls-1:0] w_ovf;
  logic [OccW-1:0]   w_occ_nxt [NumCls];
  logic              w_req;
  logic              w_legal;
  logic [1:0]        w_cls_idx;
  logic [3:0]        w_err_nxt;
  logic [DataW-1:0]  w_data;

  assign w_tready = {bus.m_tready_sp, bus.m_tready_lsu, bus.m_tready_alu};
  assign w_data   = bus.dispatch_request[102:3];
  assign w_req    = bus.s_tvalid_req && r_s_tready;

  always_comb begin
    w_legal   = 1'b1;
    w_cls_idx = 2'd0;
    case (bus.dispatch_request[2:0])
      3'b100:  w_cls_idx = 2'd0;
      3'b010:  w_cls_idx = 2'd1;
      3'b001:  w_cls_idx = 2'd2;
      default: w_legal = 1'b0;
    endcase
  end

  always_comb begin
    w_push    = '0;
    w_pop     = '0;
    w_full    = '0;
    w_accept  = '0;
    w_ovf     = '0;
    w_err_nxt = '0;
    for (int c = 0; c < NumCls; c++) begin
      w_push[c]   = w_req && w_legal && (w_cls_idx == 2'(c)) && !bus.flush;
      w_pop[c]    = (r_occ[c] != '0) && w_tready[c];
      w_full[c]   = (r_occ[c] == OccW'(DEPTH));
      // A pop in the same cycle frees the slot, so a full queue still accepts.
      w_accept[c] = w_push[c] && (!w_full[c] || w_pop[c]);
      w_ovf[c]    = w_push[c] && w_full[c] && !w_pop[c];
      w_occ_nxt[c] = r_occ[c] + OccW'(w_accept[c]) - OccW'(w_pop[c]);
    end
    w_err_nxt[0]   = w_req && !w_legal && !bus.flush;
    w_err_nxt[3:1] = w_ovf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < NumCls; c++) begin
        r_wptr[c] <= '0;
        r_rptr[c] <= '0;
        r_occ[c]  <= '0;
      end
      r_sched_ready <= '1;
      r_s_tready    <= 1'b1;
      r_err         <= '0;
    end else if (bus.flush) begin
      for (int c = 0; c < NumCls; c++) begin
        r_wptr[c] <= '0;
        r_rptr[c] <= '0;
        r_occ[c]  <= '0;
      end
      r_sched_ready <= '1;
      // Hold off the scheduler for the one cycle after a flush.
      r_s_tready    <= 1'b0;
      r_err         <= '0;
    end else begin
      for (int c = 0; c < NumCls; c++) begin
        r_occ[c] <= w_occ_nxt[c];
        if (w_accept[c]) r_wptr[c] <= r_wptr[c] + 1'b1;
        if (w_pop[c])    r_rptr[c] <= r_rptr[c] + 1'b1;
        // Two slots of headroom cover the scheduler's sample-then-push latency.
        r_sched_ready[c] <= (w_occ_nxt[c] <= OccW'(DEPTH - 2));
      end
      r_s_tready <= 1'b1;
      r_err      <= w_err_nxt;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    for (int c = 0; c < NumCls; c++) begin
      if (w_accept[c]) r_mem[c][r_wptr[c]] <= w_data;
    end
  end

  assign bus.s_tready_req    = r_s_tready;
  assign bus.sched_ready_alu = r_sched_ready[0];
  assign bus.sched_ready_lsu = r_sched_ready[1];
  assign bus.sched_ready_sp  = r_sched_ready[2];

  assign bus.m_tvalid_alu = (r_occ[0] != '0);
  assign bus.m_tvalid_lsu = (r_occ[1] != '0);
  assign bus.m_tvalid_sp  = (r_occ[2] != '0);

  assign bus.m_tdata_alu = r_mem[0][r_rptr[0]];
  assign bus.m_tdata_lsu = r_mem[1][r_rptr[1]];
  assign bus.m_tdata_sp  = r_mem[2][r_rptr[2]];

  assign bus.occ_alu = r_occ[0];
  assign bus.occ_lsu = r_occ[1];
  assign bus.occ_sp  = r_occ[2];

  assign bus.err = {28'd0, r_err};

endmodule

// File: tb/tb_dispatch_request_router.sv
module tb_dispatch_request_router;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dispatch_request_router_if #(.DEPTH(DEPTH)) bus ();

  dispatch_request_router #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic       v;
    logic [2:0] cls;
    logic [4:0] warp;
    logic [2:0] rdy;   // [0] alu, [1] lsu, [2] sp
    logic [2:0] oa, ol, os;
    logic [2:0] vld;   // {sp, lsu, alu}
    logic [2:0] srdy;  // {sp, lsu, alu}
    logic [3:0] err;
    int         ha, hl, hs;  // expected head warp, -1 = don't care
  } vec_t;

  vec_t vecs [28];

  task automatic chk(input string name, input logic [99:0] act, input logic [99:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [102:0] mk_req(input logic [4:0] warp, input logic [2:0] cls);
    logic [62:0] ins;
    logic [31:0] pred;
    ins  = 63'h1234_5678_9ABC_DEF0 ^ {58'd0, warp};
    pred = 32'hA5A5_0000 | {27'd0, warp};
    return {warp, ins, pred, cls};
  endfunction

  function automatic vec_t mkv(input logic v, input logic [2:0] cls, input logic [4:0] warp,
                               input logic [2:0] rdy, input logic [2:0] oa, input logic [2:0] ol,
                               input logic [2:0] os, input logic [2:0] vld, input logic [2:0] srdy,
                               input logic [3:0] err, input int ha, input int hl, input int hs);
    vec_t r;
    r.v = v; r.cls = cls; r.warp = warp; r.rdy = rdy;
    r.oa = oa; r.ol = ol; r.os = os; r.vld = vld; r.srdy = srdy; r.err = err;
    r.ha = ha; r.hl = hl; r.hs = hs;
    return r;
  endfunction

  // Drive one cycle of inputs at the falling edge; return just after the next rising edge.
  task automatic drive(input logic v, input logic [2:0] cls, input logic [4:0] warp,
                       input logic [2:0] rdy, input logic fl);
    @(negedge clk);
    bus.s_tvalid_req     = v;
    bus.dispatch_request = mk_req(warp, cls);
    bus.m_tready_alu     = rdy[0];
    bus.m_tready_lsu     = rdy[1];
    bus.m_tready_sp      = rdy[2];
    bus.flush            = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_state(input string tag, input logic exp_stready);
    chk({tag, " occ_alu"}, 100'(bus.occ_alu), 100'd0);
    chk({tag, " occ_lsu"}, 100'(bus.occ_lsu), 100'd0);
    chk({tag, " occ_sp"},  100'(bus.occ_sp), 100'd0);
    chk({tag, " m_tvalid"}, 100'({bus.m_tvalid_sp, bus.m_tvalid_lsu, bus.m_tvalid_alu}), 100'd0);
    chk({tag, " sched_ready"},
        100'({bus.sched_ready_sp, bus.sched_ready_lsu, bus.sched_ready_alu}), 100'h7);
    chk({tag, " err"}, 100'(bus.err), 100'd0);
    chk({tag, " s_tready_req"}, 100'(bus.s_tready_req), 100'(exp_stready));
  endtask

  logic [99:0] mq0[$], mq1[$], mq2[$];
  int got [3];

  initial begin
    // Table: v cls warp rdy | occ_a occ_l occ_s vld srdy err | head warps
    vecs[0]  = mkv(0, 3'b000, 0,  3'b000, 0, 0, 0, 3'b000, 3'b111, 0, -1, -1, -1);
    vecs[1]  = mkv(1, 3'b100, 3,  3'b000, 1, 0, 0, 3'b001, 3'b111, 0,  3, -1, -1);
    vecs[2]  = mkv(0, 3'b000, 0,  3'b001, 0, 0, 0, 3'b000, 3'b111, 0, -1, -1, -1);
    vecs[3]  = mkv(1, 3'b010, 1,  3'b000, 0, 1, 0, 3'b010, 3'b111, 0, -1,  1, -1);
    vecs[4]  = mkv(1, 3'b010, 2,  3'b000, 0, 2, 0, 3'b010, 3'b111, 0, -1,  1, -1);
    vecs[5]  = mkv(1, 3'b010, 3,  3'b000, 0, 3, 0, 3'b010, 3'b101, 0, -1,  1, -1);
    vecs[6]  = mkv(1, 3'b010, 4,  3'b000, 0, 4, 0, 3'b010, 3'b101, 0, -1,  1, -1);
    vecs[7]  = mkv(1, 3'b010, 5,  3'b000, 0, 4, 0, 3'b010, 3'b101, 4, -1,  1, -1);
    vecs[8]  = mkv(1, 3'b100, 6,  3'b000, 1, 4, 0, 3'b011, 3'b101, 0,  6,  1, -1);
    vecs[9]  = mkv(0, 3'b000, 0,  3'b000, 1, 4, 0, 3'b011, 3'b101, 0,  6,  1, -1);
    vecs[10] = mkv(1, 3'b011, 7,  3'b000, 1, 4, 0, 3'b011, 3'b101, 1,  6,  1, -1);
    vecs[11] = mkv(1, 3'b000, 7,  3'b000, 1, 4, 0, 3'b011, 3'b101, 1,  6,  1, -1);
    vecs[12] = mkv(0, 3'b000, 0,  3'b010, 1, 3, 0, 3'b011, 3'b101, 0,  6,  2, -1);
    vecs[13] = mkv(0, 3'b000, 0,  3'b010, 1, 2, 0, 3'b011, 3'b111, 0,  6,  3, -1);
    vecs[14] = mkv(1, 3'b010, 7,  3'b010, 1, 2, 0, 3'b011, 3'b111, 0,  6,  4, -1);
    vecs[15] = mkv(0, 3'b000, 0,  3'b010, 1, 1, 0, 3'b011, 3'b111, 0,  6,  7, -1);
    vecs[16] = mkv(0, 3'b000, 0,  3'b011, 0, 0, 0, 3'b000, 3'b111, 0, -1, -1, -1);
    vecs[17] = mkv(1, 3'b001, 9,  3'b000, 0, 0, 1, 3'b100, 3'b111, 0, -1, -1,  9);
    vecs[18] = mkv(0, 3'b000, 0,  3'b100, 0, 0, 0, 3'b000, 3'b111, 0, -1, -1, -1);
    vecs[19] = mkv(1, 3'b100, 10, 3'b000, 1, 0, 0, 3'b001, 3'b111, 0, 10, -1, -1);
    vecs[20] = mkv(1, 3'b100, 11, 3'b000, 2, 0, 0, 3'b001, 3'b111, 0, 10, -1, -1);
    vecs[21] = mkv(1, 3'b100, 12, 3'b000, 3, 0, 0, 3'b001, 3'b110, 0, 10, -1, -1);
    vecs[22] = mkv(1, 3'b100, 13, 3'b000, 4, 0, 0, 3'b001, 3'b110, 0, 10, -1, -1);
    vecs[23] = mkv(1, 3'b100, 14, 3'b001, 4, 0, 0, 3'b001, 3'b110, 0, 11, -1, -1);
    vecs[24] = mkv(0, 3'b000, 0,  3'b001, 3, 0, 0, 3'b001, 3'b110, 0, 12, -1, -1);
    vecs[25] = mkv(0, 3'b000, 0,  3'b001, 2, 0, 0, 3'b001, 3'b111, 0, 13, -1, -1);
    vecs[26] = mkv(0, 3'b000, 0,  3'b001, 1, 0, 0, 3'b001, 3'b111, 0, 14, -1, -1);
    vecs[27] = mkv(0, 3'b000, 0,  3'b001, 0, 0, 0, 3'b000, 3'b111, 0, -1, -1, -1);

    bus.s_tvalid_req     = 1'b0;
    bus.dispatch_request = '0;
    bus.flush            = 1'b0;
    bus.m_tready_alu     = 1'b0;
    bus.m_tready_lsu     = 1'b0;
    bus.m_tready_sp      = 1'b0;

    repeat (3) @(negedge clk);
    chk_idle_state("reset", 1'b1);
    rst_n = 1'b1;

    for (int i = 0; i < 28; i++) begin
      drive(vecs[i].v, vecs[i].cls, vecs[i].warp, vecs[i].rdy, 1'b0);
      chk($sformatf("v%0d occ_alu", i), 100'(bus.occ_alu), 100'(vecs[i].oa));
      chk($sformatf("v%0d occ_lsu", i), 100'(bus.occ_lsu), 100'(vecs[i].ol));
      chk($sformatf("v%0d occ_sp", i),  100'(bus.occ_sp),  100'(vecs[i].os));
      chk($sformatf("v%0d m_tvalid", i),
          100'({bus.m_tvalid_sp, bus.m_tvalid_lsu, bus.m_tvalid_alu}), 100'(vecs[i].vld));
      chk($sformatf("v%0d sched_ready", i),
          100'({bus.sched_ready_sp, bus.sched_ready_lsu, bus.sched_ready_alu}),
          100'(vecs[i].srdy));
      chk($sformatf("v%0d err", i), 100'(bus.err), 100'(vecs[i].err));
      chk($sformatf("v%0d s_tready_req", i), 100'(bus.s_tready_req), 100'd1);
      if (vecs[i].ha >= 0) begin
        chk($sformatf("v%0d head_alu", i), 100'(bus.m_tdata_alu), 100'(mk_req(5'(vecs[i].ha), 3'b100) >> 3));
      end
      if (vecs[i].hl >= 0) begin
        chk($sformatf("v%0d head_lsu", i), 100'(bus.m_tdata_lsu), 100'(mk_req(5'(vecs[i].hl), 3'b010) >> 3));
      end
      if (vecs[i].hs >= 0) begin
        chk($sformatf("v%0d head_sp", i), 100'(bus.m_tdata_sp), 100'(mk_req(5'(vecs[i].hs), 3'b001) >> 3));
      end
    end

    // Random-stall stream: 18 entries, 6 per class, pushed only while sched_ready allows.
    begin
      int k;
      logic [2:0] rdy;
      logic [102:0] req;
      logic sr;
      k = 0;
      got[0] = 0; got[1] = 0; got[2] = 0;
      for (int cyc = 0; cyc < 600 && (got[0] + got[1] + got[2]) < 18; cyc++) begin
        @(negedge clk);
        rdy = 3'($urandom_range(0, 7));
        bus.m_tready_alu = rdy[0];
        bus.m_tready_lsu = rdy[1];
        bus.m_tready_sp  = rdy[2];
        if (bus.m_tvalid_alu && rdy[0]) begin
          if (mq0.size() == 0) chk("rand alu unexpected pop", 100'd1, 100'd0);
          else chk("rand alu data", bus.m_tdata_alu, mq0.pop_front());
          got[0]++;
        end
        if (bus.m_tvalid_lsu && rdy[1]) begin
          if (mq1.size() == 0) chk("rand lsu unexpected pop", 100'd1, 100'd0);
          else chk("rand lsu data", bus.m_tdata_lsu, mq1.pop_front());
          got[1]++;
        end
        if (bus.m_tvalid_sp && rdy[2]) begin
          if (mq2.size() == 0) chk("rand sp unexpected pop", 100'd1, 100'd0);
          else chk("rand sp data", bus.m_tdata_sp, mq2.pop_front());
          got[2]++;
        end
        chk("rand err", 100'(bus.err), 100'd0);
        bus.s_tvalid_req = 1'b0;
        if (k < 18) begin
          sr = (k % 3 == 0) ? bus.sched_ready_alu :
               (k % 3 == 1) ? bus.sched_ready_lsu : bus.sched_ready_sp;
          if (sr) begin
            req = {5'(k), 31'($urandom()), $urandom(), $urandom(),
                   (k % 3 == 0) ? 3'b100 : (k % 3 == 1) ? 3'b010 : 3'b001};
            bus.dispatch_request = req;
            bus.s_tvalid_req     = 1'b1;
            if (k % 3 == 0) mq0.push_back(req[102:3]);
            else if (k % 3 == 1) mq1.push_back(req[102:3]);
            else mq2.push_back(req[102:3]);
            k++;
          end
        end
      end
      chk("rand drained alu", 100'(got[0]), 100'd6);
      chk("rand drained lsu", 100'(got[1]), 100'd6);
      chk("rand drained sp",  100'(got[2]), 100'd6);
    end

    // Flush with two entries per queue and a simultaneous push.
    drive(1, 3'b100, 1, 3'b000, 0);
    drive(1, 3'b100, 2, 3'b000, 0);
    drive(1, 3'b010, 3, 3'b000, 0);
    drive(1, 3'b010, 4, 3'b000, 0);
    drive(1, 3'b001, 5, 3'b000, 0);
    drive(1, 3'b001, 6, 3'b000, 0);
    chk("pre-flush occ_sp", 100'(bus.occ_sp), 100'd2);
    drive(1, 3'b100, 20, 3'b000, 1);
    chk_idle_state("flush", 1'b0);
    // s_tready_req is low this cycle, so the push is not taken.
    drive(1, 3'b100, 21, 3'b000, 0);
    chk_idle_state("post-flush", 1'b1);
    drive(1, 3'b100, 22, 3'b000, 0);
    chk("after flush occ_alu", 100'(bus.occ_alu), 100'd1);
    chk("after flush head_alu", bus.m_tdata_alu, 100'(mk_req(5'd22, 3'b100) >> 3));

    // Asynchronous reset in the middle of traffic, with an error flag pending.
    drive(1, 3'b010, 23, 3'b000, 0);
    drive(1, 3'b000, 24, 3'b000, 0);
    chk("pre-reset err", 100'(bus.err), 100'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_state("async reset", 1'b1);
    bus.s_tvalid_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 3'b000, 0, 3'b000, 0);
    chk_idle_state("after reset", 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
